// File: rtl/fft_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_sched_pkg
// Description : Shared types and constants for the FFT frame scheduler:
//               FSM state encoding, FFT core reset length and default
//               auto-trigger period / collect watchdog limits.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FFT_RST = 3'd1,
      ST_FEED    = 3'd2,
      ST_COLLECT = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   // Clocks the FFT core is held in reset before each frame.
   localparam int FFT_RST_CYC     = 2;
   // 0.5 s at 50 MHz.
   localparam int DEF_PERIOD_CYC  = 25_000_000;
   localparam int DEF_TIMEOUT_CYC = 4096;

endpackage
`default_nettype wire

// File: rtl/fft_frame_sched_period_tick.sv
`default_nettype none
// ============================================================================
// Module      : period_tick
// Description : Free-running period counter with enable. Emits a one-cycle
//               tick every PERIOD_CYC clocks while enabled; the count is held
//               at zero while disabled, so the first tick comes PERIOD_CYC-1
//               clocks after the enable rises.
// Ports       : clk, rst_n (async, active-low), en_i (count enable),
//               tick_o (one-cycle pulse, combinational from the count)
// Revision    : 1.0 - initial release
// ============================================================================
module period_tick
   import fft_sched_pkg::*;
#(
   parameter int PERIOD_CYC = DEF_PERIOD_CYC
)(
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

   logic [CNT_W-1:0] cnt_q;

   assign tick_o = en_i && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!en_i || tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fft_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_sched
// Description : FFT analysis frame scheduler. Triggers a frame manually or
//               periodically, resets the FFT core, gates N ADC samples into
//               the FFT input stream with tlast on the N-th, then writes the
//               magnitude bins into the spectrum RAM (optionally only the
//               lower half). Flags dropped triggers and aborts a stalled
//               collect phase with a watchdog.
// Ports       : clk, rst_n           - clock, async active-low reset
//               start, auto_en      - manual trigger / periodic enable
//               sample_valid        - ADC sample strobe
//               fft_in_*            - FFT input stream handshake + tlast
//               fft_aresetn         - FFT core reset (active-low)
//               mag_data/mag_valid  - magnitude stream from the FFT path
//               wr_en/addr/data     - spectrum RAM write port (registered)
//               busy, frame_done, overrun, timeout, frame_cnt - status
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_sched
   import fft_sched_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 16,
   parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
   parameter int HALF_ONLY   = 1,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              auto_en,
   input  logic              sample_valid,
   input  logic              fft_in_ready,
   output logic              fft_in_valid,
   output logic              fft_in_last,
   output logic              fft_aresetn,
   input  logic [DATA_W-1:0] mag_data,
   input  logic              mag_valid,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              frame_done,
   output logic              overrun,
   output logic              timeout,
   output logic [15:0]       frame_cnt
);

   localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int RC_W = (FFT_RST_CYC > 1) ? $clog2(FFT_RST_CYC) : 1;
   localparam logic [ADDR_W-1:0] LAST_IDX = '1;
   localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
   localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(FFT_RST_CYC - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   smp_q, smp_d;
   logic [ADDR_W-1:0]   bin_q, bin_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [RC_W-1:0]     rc_q, rc_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                done_q, done_d;
   logic                ovr_q, ovr_d;
   logic                to_q, to_d;
   logic [15:0]         fcnt_q, fcnt_d;
   logic                aresetn_q, aresetn_d;
   logic                auto_tick;
   logic                trigger;
   logic                store_bin;

   period_tick #(
      .PERIOD_CYC (PERIOD_CYC)
   ) u_period_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (auto_en),
      .tick_o (auto_tick)
   );

   // A coincident start and auto tick is a single trigger.
   assign trigger = start | auto_tick;

   // In half-spectrum mode only bins with a clear MSB (0..N/2-1) are stored.
   assign store_bin = (HALF_ONLY != 0) ? ~bin_q[ADDR_W-1] : 1'b1;

   assign fft_in_valid = (state_q == ST_FEED) & sample_valid;
   assign fft_in_last  = fft_in_valid & (smp_q == LAST_IDX);

   always_comb begin
      state_d   = state_q;
      smp_d     = smp_q;
      bin_d     = bin_q;
      wd_d      = wd_q;
      rc_d      = '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      done_d    = 1'b0;
      to_d      = 1'b0;
      fcnt_d    = fcnt_q;
      ovr_d     = trigger & (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            smp_d = '0;
            bin_d = '0;
            wd_d  = '0;
            if (trigger) state_d = ST_FFT_RST;
         end
         ST_FFT_RST: begin
            if (rc_q == RC_LAST) state_d = ST_FEED;
            else                 rc_d    = rc_q + 1'b1;
         end
         ST_FEED: begin
            // Sample index wraps back to zero on the accepted last sample.
            if (fft_in_valid && fft_in_ready) begin
               smp_d = smp_q + 1'b1;
               if (fft_in_last) state_d = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            wd_d = wd_q + 1'b1;
            if (mag_valid) begin
               bin_d = bin_q + 1'b1;
               if (store_bin) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = bin_q;
                  wr_data_d = mag_data;
               end
            end
            // Completion wins over a watchdog expiry in the same cycle.
            if (mag_valid && (bin_q == LAST_IDX)) begin
               state_d = ST_DONE;
            end else if (wd_q == WD_LAST) begin
               to_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      aresetn_d = (state_d != ST_FFT_RST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         smp_q     <= '0;
         bin_q     <= '0;
         wd_q      <= '0;
         rc_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         ovr_q     <= 1'b0;
         to_q      <= 1'b0;
         fcnt_q    <= '0;
         aresetn_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         smp_q     <= smp_d;
         bin_q     <= bin_d;
         wd_q      <= wd_d;
         rc_q      <= rc_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         ovr_q     <= ovr_d;
         to_q      <= to_d;
         fcnt_q    <= fcnt_d;
         aresetn_q <= aresetn_d;
      end
   end

   assign fft_aresetn = aresetn_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign busy        = (state_q != ST_IDLE);
   assign frame_done  = done_q;
   assign overrun     = ovr_q;
   assign timeout     = to_q;
   assign frame_cnt   = fcnt_q;

endmodule
`default_nettype wire
